// File: rtl/delta_pkg.sv
// Shared types and constants for the multi-channel delta-modulation spike encoder.
package delta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_e;

    localparam logic [1:0] SPIKE_NONE = 2'b00;
    localparam logic [1:0] SPIKE_ON   = 2'b01;
    localparam logic [1:0] SPIKE_OFF  = 2'b10;

    // Channel index width; a single channel still needs one bit.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/delta_compare.sv
// Combinational delta comparator: decides the spike for one sample against its
// reference and computes the reference that follows.
module delta_compare
    import delta_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int REF_MODE = 0
) (
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] ref_i,
    input  logic [WIDTH-1:0] threshold_i,
    input  logic             off_en_i,
    output logic [1:0]       spike_o,
    output logic             update_o,
    output logic [WIDTH-1:0] next_ref_o
);

    logic             rising;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] stepped;

    always_comb begin
        rising   = sample_i > ref_i;
        diff     = rising ? (sample_i - ref_i) : (ref_i - sample_i);
        update_o = diff > threshold_i;
        // The step cannot wrap: it is only used when diff > threshold, so the
        // stepped value stays between ref and sample.
        stepped  = rising ? (ref_i + threshold_i + 1'b1) : (ref_i - threshold_i - 1'b1);

        spike_o = SPIKE_NONE;
        if (update_o) begin
            if (rising) begin
                spike_o = SPIKE_ON;
            end else if (off_en_i) begin
                spike_o = SPIKE_OFF;
            end
        end

        next_ref_o = (REF_MODE == 1) ? stepped : sample_i;
    end

endmodule

// File: rtl/delta_encoder_mc.sv
// Multi-channel delta-modulation spike encoder: accepts a frame, scans one
// channel per cycle against its stored reference and emits ON/OFF events.
module delta_encoder_mc
    import delta_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int REF_MODE = 0,
    localparam int CW      = chan_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0]          threshold,
    input  logic                      off_spike_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_spike,
    output logic [CW-1:0]             out_chan,
    output logic                      busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never drops and its payload never changes while waiting.
    state_e                    state_q;
    logic [CW-1:0]             ch_q;
    logic                      primed_q;
    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [WIDTH-1:0]          thr_q;
    logic                      off_en_q;
    logic [WIDTH-1:0]          ref_q [CHANNELS];
    logic                      out_valid_q;
    logic [1:0]                out_spike_q;
    logic [CW-1:0]             out_chan_q;

    logic [WIDTH-1:0] sample_sel;
    logic [WIDTH-1:0] ref_sel;
    logic [1:0]       cmp_spike;
    logic             cmp_update;
    logic [WIDTH-1:0] cmp_next_ref;
    logic             last_ch;
    logic             advance;

    always_comb begin
        sample_sel = data_q[ch_q*WIDTH +: WIDTH];
        ref_sel    = ref_q[ch_q];
        last_ch    = (ch_q == CW'(CHANNELS - 1));
        advance    = ((state_q == SCAN) && (!primed_q || (cmp_spike == SPIKE_NONE)))
                   || ((state_q == EMIT) && out_ready);
    end

    delta_compare #(
        .WIDTH    (WIDTH),
        .REF_MODE (REF_MODE)
    ) u_compare (
        .sample_i    (sample_sel),
        .ref_i       (ref_sel),
        .threshold_i (thr_q),
        .off_en_i    (off_en_q),
        .spike_o     (cmp_spike),
        .update_o    (cmp_update),
        .next_ref_o  (cmp_next_ref)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            primed_q    <= 1'b0;
            data_q      <= '0;
            thr_q       <= '0;
            off_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_spike_q <= SPIKE_NONE;
            out_chan_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                ref_q[c] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        thr_q    <= threshold;
                        off_en_q <= off_spike_en;
                        ch_q     <= '0;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!primed_q) begin
                        ref_q[ch_q] <= sample_sel;
                    end else if (cmp_spike != SPIKE_NONE) begin
                        out_spike_q <= cmp_spike;
                        out_chan_q  <= ch_q;
                        out_valid_q <= 1'b1;
                        ref_q[ch_q] <= cmp_next_ref;
                        state_q     <= EMIT;
                    end else if (cmp_update) begin
                        // Suppressed OFF: the reference still follows the sample.
                        ref_q[ch_q] <= cmp_next_ref;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (advance) begin
                if (last_ch) begin
                    primed_q <= 1'b1;
                    state_q  <= IDLE;
                end else begin
                    ch_q    <= ch_q + 1'b1;
                    state_q <= SCAN;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_spike = out_spike_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_delta_encoder_mc.sv
// Bench for delta_encoder_mc: one instance per reference mode, a frame-level
// event model with expected queues, and directed frames with literal checks.
module tb_delta_encoder_mc;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst       [2];
    logic           in_valid  [2];
    logic [N*W-1:0] in_data   [2];
    logic [W-1:0]   thr       [2];
    logic           off_en    [2];
    logic           out_ready [2];

    logic           in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
    logic [1:0]     out_spike0, out_spike1;
    logic [CW-1:0]  out_chan0, out_chan1;

    logic           in_ready_a  [2];
    logic           out_valid_a [2];
    logic           busy_a      [2];
    logic [1:0]     out_spike_a [2];
    logic [CW-1:0]  out_chan_a  [2];

    always_comb begin
        in_ready_a[0]  = in_ready0;   in_ready_a[1]  = in_ready1;
        out_valid_a[0] = out_valid0;  out_valid_a[1] = out_valid1;
        busy_a[0]      = busy0;       busy_a[1]      = busy1;
        out_spike_a[0] = out_spike0;  out_spike_a[1] = out_spike1;
        out_chan_a[0]  = out_chan0;   out_chan_a[1]  = out_chan1;
    end

    delta_encoder_mc #(.WIDTH(W), .CHANNELS(N), .REF_MODE(0)) dut0 (
        .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready0),
        .in_data(in_data[0]), .threshold(thr[0]), .off_spike_en(off_en[0]),
        .out_valid(out_valid0), .out_ready(out_ready[0]), .out_spike(out_spike0),
        .out_chan(out_chan0), .busy(busy0)
    );

    delta_encoder_mc #(.WIDTH(W), .CHANNELS(N), .REF_MODE(1)) dut1 (
        .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready1),
        .in_data(in_data[1]), .threshold(thr[1]), .off_spike_en(off_en[1]),
        .out_valid(out_valid1), .out_ready(out_ready[1]), .out_spike(out_spike1),
        .out_chan(out_chan1), .busy(busy1)
    );

    int checks   = 0;
    int failures = 0;

    // Expected events {chan, spike} per instance; observed log {inst, chan, spike}.
    logic [3:0] exp_q0 [$];
    logic [3:0] exp_q1 [$];
    logic [4:0] obs_q  [$];

    int mref    [2][N];
    bit mprimed [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic void model_reset(input int d);
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
        mprimed[d] = 1'b0;
        for (int c = 0; c < N; c++) mref[d][c] = 0;
    endfunction

    // Frame-level rules: strict threshold, ON when rising, OFF only when enabled,
    // reference moves whenever the threshold is exceeded.
    function automatic void model_frame(input int d, input int s[N], input int t, input bit off);
        logic [3:0] ev;
        for (int c = 0; c < N; c++) begin
            int r;
            r = mref[d][c];
            if (!mprimed[d]) begin
                mref[d][c] = s[c];
            end else if (s[c] > r && (s[c] - r) > t) begin
                ev = {c[1:0], 2'b01};
                if (d == 0) exp_q0.push_back(ev); else exp_q1.push_back(ev);
                mref[d][c] = (d == 1) ? r + t + 1 : s[c];
            end else if (s[c] < r && (r - s[c]) > t) begin
                ev = {c[1:0], 2'b10};
                if (off) begin
                    if (d == 0) exp_q0.push_back(ev); else exp_q1.push_back(ev);
                end
                mref[d][c] = (d == 1) ? r - t - 1 : s[c];
            end
        end
        mprimed[d] = 1'b1;
    endfunction

    task automatic send_frame(input int d, input int s0, input int s1, input int s2,
                              input int s3, input int t, input bit off);
        int s[N];
        int waited;
        s = '{s0, s1, s2, s3};
        waited = 0;
        @(negedge clk);
        while (!in_ready_a[d] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_frame", {31'd0, in_ready_a[d]}, 32'd1);
        for (int c = 0; c < N; c++) in_data[d][c*W +: W] = s[c][W-1:0];
        thr[d]      = t[W-1:0];
        off_en[d]   = off;
        in_valid[d] = 1'b1;
        model_frame(d, s, t, off);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        // Mid-frame changes must be ignored by the frame in flight.
        thr[d]    = '0;
        off_en[d] = ~off;
    endtask

    task automatic wait_idle(input int d, input string name);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready_a[d] && !out_valid_a[d] && qsize(d) == 0) break;
            n++;
        end
        check(name, {31'd0, n < 100}, 32'd1);
    endtask

    task automatic wait_out_valid(input int d, input string name);
        int n;
        n = 0;
        while (!out_valid_a[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, out_valid_a[d]}, 32'd1);
    endtask

    task automatic pulse_reset(input int d);
        @(posedge clk);
        #2;
        rst[d] = 1'b1;
        model_reset(d);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
    endtask

    // Per-cycle compare: events against the model, hold stability under stall.
    bit         pv   [2];
    bit         pr   [2];
    logic [3:0] pdat [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [3:0] got;
            logic [3:0] exp;
            got = {out_chan_a[d], out_spike_a[d]};
            if (rst[d]) begin
                pv[d] = 1'b0;
            end else begin
                if (out_valid_a[d]) check("in_ready_low_in_emit", {31'd0, in_ready_a[d]}, 32'd0);
                if (pv[d] && !pr[d]) begin
                    check("hold_valid", {31'd0, out_valid_a[d]}, 32'd1);
                    check("hold_payload", {28'd0, got}, {28'd0, pdat[d]});
                end
                if (out_valid_a[d] && out_ready[d]) begin
                    obs_q.push_back({d[0], got});
                    if (qsize(d) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event: inst %0d got %0h expected none at %0t", d, got, $time);
                    end else begin
                        exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("event", {28'd0, got}, {28'd0, exp});
                    end
                end
                pv[d]   = out_valid_a[d];
                pr[d]   = out_ready[d];
                pdat[d] = got;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; thr[d] = '0;
            off_en[d] = 1'b0; out_ready[d] = 1'b1;
            model_reset(d);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready",  {31'd0, in_ready_a[d]},  32'd1);
            check("rst_out_valid", {31'd0, out_valid_a[d]}, 32'd0);
            check("rst_out_spike", {30'd0, out_spike_a[d]}, 32'd0);
            check("rst_out_chan",  {30'd0, out_chan_a[d]},  32'd0);
            check("rst_busy",      {31'd0, busy_a[d]},      32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Priming frame: no events, ready again exactly four cycles after accept.
        obs_q.delete();
        send_frame(0, 10, 20, 30, 40, 5, 1'b1);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (in_ready_a[0]) break;
            n++;
        end
        check("prime_latency", n, 32'd4);
        check("prime_events", obs_q.size(), 32'd0);

        // Mixed events: ON on chan 0, chan 2 silent at diff == threshold, OFF on chan 3.
        obs_q.delete();
        send_frame(0, 16, 20, 25, 30, 5, 1'b1);
        wait_idle(0, "mixed_done");
        check("mixed_count", obs_q.size(), 32'd2);
        check("mixed_ev0", {27'd0, obs_q[0]}, {27'd0, 5'b0_00_01});
        check("mixed_ev1", {27'd0, obs_q[1]}, {27'd0, 5'b0_11_10});

        // Backpressure on the first of two events (refs now 16,20,30,30).
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        obs_q.delete();
        send_frame(0, 30, 20, 10, 30, 5, 1'b1);
        wait_out_valid(0, "bp_valid");
        repeat (5) begin
            @(negedge clk);
            check("bp_chan",     {30'd0, out_chan_a[0]},  32'd0);
            check("bp_spike",    {30'd0, out_spike_a[0]}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready_a[0]},  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        wait_idle(0, "bp_done");
        check("bp_count", obs_q.size(), 32'd2);
        check("bp_ev0", {27'd0, obs_q[0]}, {27'd0, 5'b0_00_01});
        check("bp_ev1", {27'd0, obs_q[1]}, {27'd0, 5'b0_10_10});

        // Reset during EMIT drops the event; next frame primes again.
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        obs_q.delete();
        send_frame(0, 0, 20, 10, 30, 5, 1'b1);
        wait_out_valid(0, "rstemit_valid");
        @(posedge clk);
        #2;
        rst[0] = 1'b1;
        model_reset(0);
        #1;
        check("rstemit_out_valid", {31'd0, out_valid_a[0]}, 32'd0);
        check("rstemit_in_ready",  {31'd0, in_ready_a[0]},  32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        out_ready[0] = 1'b1;
        send_frame(0, 100, 0, 200, 5, 5, 1'b1);
        wait_idle(0, "reprime_done");
        check("reprime_events", obs_q.size(), 32'd0);
        send_frame(0, 120, 0, 200, 5, 5, 1'b1);
        wait_idle(0, "after_reprime_done");
        check("after_reprime_count", obs_q.size(), 32'd1);
        check("after_reprime_ev", {27'd0, obs_q[0]}, {27'd0, 5'b0_00_01});

        // OFF suppressed in jump mode still moves the reference.
        pulse_reset(0);
        obs_q.delete();
        send_frame(0, 10, 20, 30, 40, 5, 1'b1);
        wait_idle(0, "sup_prime_done");
        send_frame(0, 10, 20, 30, 20, 5, 1'b0);
        wait_idle(0, "sup_off_done");
        check("sup_off_events", obs_q.size(), 32'd0);
        send_frame(0, 10, 20, 30, 20, 5, 1'b1);
        wait_idle(0, "sup_on_done");
        check("sup_follow_events", obs_q.size(), 32'd0);

        // Step mode: ref 10 -> 16 -> 22 -> 28, then diff 2 is silent.
        send_frame(1, 10, 20, 30, 40, 5, 1'b1);
        wait_idle(1, "step_prime_done");
        for (int f = 0; f < 4; f++) begin
            obs_q.delete();
            send_frame(1, 30, 20, 30, 40, 5, 1'b1);
            wait_idle(1, "step_done");
            check("step_count", obs_q.size(), (f < 3) ? 32'd1 : 32'd0);
            if (f < 3) check("step_ev", {27'd0, obs_q[0]}, {27'd0, 5'b1_00_01});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delta_encoder_mc.md
# delta_encoder_mc

Parametrised multi-channel delta-modulation spike encoder. It accepts one frame of CHANNELS samples per valid/ready handshake and compares each sample against a per-channel stored reference, one channel per cycle. It emits ON/OFF spike events with the channel index over a valid/ready output port, with selectable reference-update mode. It replaces the single-channel combinational delta comparator, and sits between the sample front-end and the spike output serialiser.

## Interface
Parameters:
- WIDTH, 8, sample/threshold width in bits (≥2)
- CHANNELS, 4, channels per frame (≥1)
- REF_MODE, 0, reference update on spike: 0 = jump to sample; 1 = step by threshold+1 toward sample

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  frame valid
- in_ready  out  1  frame accepted when in_valid & in_ready
- in_data  in  CHANNELS*WIDTH  frame; channel c at bits [c*WIDTH +: WIDTH]
- threshold  in  WIDTH  spike threshold, sampled on frame accept
- off_spike_en  in  1  enable OFF events, sampled on frame accept
- out_valid  out  1  event valid
- out_ready  in  1  event consumed when out_valid & out_ready
- out_spike  out  2  01 = ON (rising), 10 = OFF (falling)
- out_chan  out  CW  channel index, CW = max(1, $clog2(CHANNELS))
- busy  out  1  high whenever state ≠ IDLE

## Operation
- State machine states:
  - IDLE: in_ready=1. On accept, latch in_data, threshold and off_spike_en into shadow registers. Set ch=0 and go to SCAN.
  - SCAN: evaluate channel ch against ref[ch].
    - Not primed: ref[ch] ← sample; no event.
    - Event: load out_spike/out_chan, out_valid ← 1, update ref[ch], go to EMIT.
    - No event: update ref[ch] if falling-suppressed (below); advance.
  - EMIT: hold outputs until out_ready. On handshake, out_valid ← 0 and advance.
- Advance: if ch = CHANNELS-1, set primed ← 1 and go to IDLE; otherwise ch+1 and go to SCAN.
- diff = |sample − ref|, computed at WIDTH bits with no wrap (subtract the smaller value from the larger).
- Event rules:
  - diff > threshold, strictly. diff = threshold gives no event.
  - sample > ref → ON.
  - sample < ref → OFF, only if off_spike_en. Otherwise no event, but the reference still updates exactly as for an OFF event.
  - sample = ref never produces an event.
- Reference update, applied only when diff > threshold:
  - REF_MODE 0: ref ← sample.
  - REF_MODE 1: ref ← ref ± (threshold+1), computed at WIDTH+1 bits. Overflow is impossible because diff > threshold.
- The first frame after reset is the priming frame: it loads every reference and emits no events.

## Timing
- Reset values: in_ready=1, out_valid=0, out_spike=00, out_chan=0, busy=0, all ref=0, primed=0, state IDLE. Reset takes effect immediately (asynchronous).
- Frame accepted at edge t → channel 0 evaluated at edge t+1.
- An event's out_valid goes high in the cycle after its SCAN edge.
- Frame with no events: in_ready returns high CHANNELS cycles after accept.
- Each event adds ≥1 EMIT cycle.
- in_ready is 0 throughout SCAN and EMIT. Frames are never queued.
- While out_valid=1 and out_ready=0, out_valid, out_spike and out_chan stay stable. No further channel is evaluated.
- Events are emitted in ascending channel order, at most one per channel per frame.
- Changes to threshold or off_spike_en mid-frame have no effect until the next accept.
- Reset asserted mid-SCAN or mid-EMIT: the pending event is dropped and the next frame is a priming frame.

## Structure
- Shared package delta_pkg:
  - state enum {IDLE, SCAN, EMIT}
  - constants SPIKE_NONE=2'b00, SPIKE_ON=2'b01, SPIKE_OFF=2'b10
  - function for CW
- Sub-module delta_compare: combinational. Takes sample, ref, threshold, off_en; returns spike code, an update flag and next_ref, parameterised by WIDTH and REF_MODE. Instantiated once and muxed by ch.
- Top level holds the FSM, shadow registers, ref array and output registers.

## Test plan
WIDTH=8 and CHANNELS=4 throughout.
- Priming: after reset, frame {10,20,30,40} with threshold=5 → no out_valid; in_ready high 4 cycles after accept.
- Mixed events: after priming, frame {16,20,25,30} with threshold=5 and off_spike_en=1 →
  - events (ON, chan 0) then (OFF, chan 3), in that order
  - chan 2 silent (diff = threshold)
- OFF suppressed (REF_MODE 0): after priming, frame {10,20,30,20} with off_spike_en=0 → no events. A following frame {10,20,30,20} with off_spike_en=1 → still no events, because ref[3] is already 20.
- Step mode (REF_MODE 1): ref[0]=10, frame value 30 with threshold=5, repeated →
  - ON events on frames 1–3 (ref 16, 22, 28)
  - no event on frame 4 (diff 2)
- Backpressure: hold out_ready=0 for 5 cycles during an event → out_valid, out_spike and out_chan stable; in_ready=0; no other channel evaluated. On release the scan resumes and completes normally.
- Reset mid-EMIT: assert reset while out_valid=1 → out_valid=0 and in_ready=1 immediately. The next frame produces no events (priming).
